spu_wb_queue: RTL
=================

Name: spu_wb_queue

Overview:
Writeback stage of the Cell SPU; it sits between the even/odd execution pipes and the three-ported register file.
- Both pipes can retire one result per cycle, but the register file has a single write port.
- This block buffers retiring results in program order and drains one per cycle into the regfile write port (regwrite/wa/wd).
- It stalls issue when nearly full and optionally forwards pending results to the operand read ports.

Parameters:
WIDTH, 128, data width of a result / register
REGBITS, 7, register address width (128 GPRs)
DEPTH, 4, buffer entries (power of 2, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
e_valid  input  1  even pipe result valid
e_wa  input  REGBITS  even pipe destination register
e_wd  input  WIDTH  even pipe result
o_valid  input  1  odd pipe result valid
o_wa  input  REGBITS  odd pipe destination register
o_wd  input  WIDTH  odd pipe result
stall  output  1  buffer full; pipes must hold results, issue must freeze
regwrite  output  1  registered write enable to regfile
wa  output  REGBITS  registered write address to regfile
wd  output  WIDTH  registered write data to regfile
wb_empty  output  1  nothing pending (buffer empty and regwrite low)
drop_err  output  1  sticky: a valid result arrived while stall was high
fwd_ra1, fwd_ra2  input  REGBITS  operand addresses being read (WB_FWD_EN only)
fwd_hit1, fwd_hit2  output  1  pending write to fwd_raN exists (WB_FWD_EN only)
fwd_d1, fwd_d2  output  WIDTH  youngest pending data for fwd_raN (WB_FWD_EN only)

Behaviour:
- Ordering: within one cycle the even result is older than the odd result. All older buffered entries precede both.
- Candidate list each edge: buffer entries oldest-first, then even result (if e_valid && !stall), then odd result (if o_valid && !stall).
- Drain: at each rising edge with candidates present, the oldest candidate loads wa/wd and regwrite=1. The remaining candidates are stored in order in the buffer.
- With no candidates, regwrite=0 and wa/wd hold their values.
- Latency: a result accepted at edge N with the buffer empty appears on regwrite/wa/wd after edge N, i.e. one cycle.
- count = buffer occupancy, 0..DEPTH, excluding the output register. Net change per edge is at most +1.
- stall = (count == DEPTH), combinational from registered count.
  - While stall is high, e_valid/o_valid are ignored and drop_err is set.
  - Draining continues, so stall deasserts after one edge.
- Same destination: two entries with the same address are both written, in order. The final regfile value is the younger entry (odd beats even in the same cycle).
- Register 0 is not special; writes to it are buffered and drained like any other.
- Buffer is a circular FIFO with head/tail pointers of log2(DEPTH) bits wrapping modulo DEPTH. Correct at count==DEPTH with head==tail.
- wb_empty = (count==0) && !regwrite.
- Reset (any time, including mid-drain):
  - count=0, pointers=0, regwrite=0, wa=0, wd=0, drop_err=0, stall=0.
  - Pending entries are discarded.
  - Inputs on the reset cycle are ignored.

Optional Feature:
WB_FWD_EN
- Defined:
  - fwd_hitN=1 when fwd_raN matches any buffer entry or the output register while regwrite=1.
  - fwd_dN is the data of the youngest match. Priority: newest buffer entry, then older entries, then the output register.
  - Output-register data must be forwarded because the regfile samples its read ports on the same edge the write lands, and reads the old value.
  - Purely combinational from registered state; incoming e_/o_ results are not forwarded.
- Undefined: fwd_* ports are absent and no comparators are built.

Test Plan:
1. Reset, then e_valid=1, e_wa=5, e_wd=0xA5 for one cycle -> next cycle regwrite=1, wa=5, wd=0xA5; the cycle after, regwrite=0 and wb_empty=1.
2. e_valid=o_valid=1 (e: wa=3, wd=1; o: wa=3, wd=2) -> two consecutive regwrites, to 3 with wd=1 then to 3 with wd=2; odd value is last.
3. Both pipes valid for 6 consecutive cycles, DEPTH=4 -> count rises by 1 per cycle and stall=1 when count==4. Producers hold while stalled. All 12 writes drain in exact program order, no loss, drop_err=0.
4. Assert e_valid while stall=1 -> result not enqueued, drop_err=1 and stays 1 until reset.
5. With WB_FWD_EN: enqueue wa=9 wd=0x11 then wa=9 wd=0x22, set fwd_ra1=9 -> fwd_hit1=1, fwd_d1=0x22. Once both have drained and regwrite=0, fwd_hit1=0.
6. Fill buffer to 3 entries, assert reset for one cycle with e_valid=1 -> regwrite=0 after the reset edge and no further writes; wb_empty=1, stall=0.

Source files
------------

// File: rtl/spu_wb_queue_if.sv
// Pipe-to-writeback bundle for spu_wb_queue: retiring results in,
// regfile write port and status out.
interface spu_wb_queue_if #(
    parameter int WIDTH   = 128,
    parameter int REGBITS = 7
);
    logic               e_valid;
    logic [REGBITS-1:0] e_wa;
    logic [WIDTH-1:0]   e_wd;
    logic               o_valid;
    logic [REGBITS-1:0] o_wa;
    logic [WIDTH-1:0]   o_wd;
    logic               stall;
    logic               regwrite;
    logic [REGBITS-1:0] wa;
    logic [WIDTH-1:0]   wd;
    logic               wb_empty;
    logic               drop_err;

    modport master (
        output e_valid, e_wa, e_wd, o_valid, o_wa, o_wd,
        input  stall, regwrite, wa, wd, wb_empty, drop_err
    );

    modport slave (
        input  e_valid, e_wa, e_wd, o_valid, o_wa, o_wd,
        output stall, regwrite, wa, wd, wb_empty, drop_err
    );
endinterface

// File: rtl/spu_wb_queue.sv
// SPU writeback queue: merges even/odd results in program order onto one
// regfile write port. Define WB_FWD_EN to build operand forwarding.
module spu_wb_queue #(
    parameter int WIDTH   = 128,
    parameter int REGBITS = 7,
    parameter int DEPTH   = 4
) (
    input logic           clk,
    input logic           reset,
    spu_wb_queue_if.slave bus
`ifdef WB_FWD_EN
    ,
    input  logic [REGBITS-1:0] fwd_ra1,
    input  logic [REGBITS-1:0] fwd_ra2,
    output logic               fwd_hit1,
    output logic               fwd_hit2,
    output logic [WIDTH-1:0]   fwd_d1,
    output logic [WIDTH-1:0]   fwd_d2
`endif
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [PW:0]        count;
    logic [REGBITS-1:0] buf_wa [DEPTH];
    logic [WIDTH-1:0]   buf_wd [DEPTH];

    logic               regwrite_q;
    logic [REGBITS-1:0] wa_q;
    logic [WIDTH-1:0]   wd_q;
    logic               drop_q;

    logic               stall;
    logic               e_acc;
    logic               o_acc;
    logic               have_buf;
    logic               push_e;
    logic               push_o;
    logic [PW-1:0]      tail_o;
    logic [PW:0]        count_nxt;
    logic               out_go;
    logic [REGBITS-1:0] out_wa;
    logic [WIDTH-1:0]   out_wd;

    assign stall    = (count == (PW+1)'(DEPTH));
    assign e_acc    = bus.e_valid && !stall;
    assign o_acc    = bus.o_valid && !stall;
    assign have_buf = (count != '0);

    // The oldest candidate leaves; everything younger lands in the FIFO.
    assign push_e    = e_acc && have_buf;
    assign push_o    = o_acc && (have_buf || e_acc);
    assign tail_o    = tail + PW'(push_e);
    assign count_nxt = count + (PW+1)'(push_e) + (PW+1)'(push_o)
                     - (PW+1)'(have_buf);

    always_comb begin
        out_go = 1'b0;
        out_wa = wa_q;
        out_wd = wd_q;
        unique case (1'b1)
            have_buf: begin
                out_go = 1'b1;
                out_wa = buf_wa[head];
                out_wd = buf_wd[head];
            end
            (e_acc && !have_buf): begin
                out_go = 1'b1;
                out_wa = bus.e_wa;
                out_wd = bus.e_wd;
            end
            (o_acc && !have_buf && !e_acc): begin
                out_go = 1'b1;
                out_wa = bus.o_wa;
                out_wd = bus.o_wd;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            drop_q     <= 1'b0;
        end else begin
            if (stall && (bus.e_valid || bus.o_valid))
                drop_q <= 1'b1;
            regwrite_q <= out_go;
            if (out_go) begin
                wa_q <= out_wa;
                wd_q <= out_wd;
            end
            if (have_buf)
                head <= head + PW'(1);
            tail  <= tail_o + PW'(push_o);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push_e) begin
                buf_wa[tail] <= bus.e_wa;
                buf_wd[tail] <= bus.e_wd;
            end
            if (push_o) begin
                buf_wa[tail_o] <= bus.o_wa;
                buf_wd[tail_o] <= bus.o_wd;
            end
        end
    end

    assign bus.stall    = stall;
    assign bus.regwrite = regwrite_q;
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign bus.wb_empty = !have_buf && !regwrite_q;
    assign bus.drop_err = drop_q;

`ifdef WB_FWD_EN
    // Walk oldest to newest so the youngest match overrides.
    function automatic logic [WIDTH:0] lookup(
        input logic [REGBITS-1:0] ra
    );
        logic             hit;
        logic [WIDTH-1:0] d;
        logic [PW-1:0]    idx;
        hit = regwrite_q && (wa_q == ra);
        d   = hit ? wd_q : '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (((PW+1)'(k) < count) && (buf_wa[idx] == ra)) begin
                hit = 1'b1;
                d   = buf_wd[idx];
            end
        end
        return {hit, d};
    endfunction

    assign {fwd_hit1, fwd_d1} = lookup(fwd_ra1);
    assign {fwd_hit2, fwd_d2} = lookup(fwd_ra2);
`endif
endmodule
